spi_triangle_rx: RTL and testbench



---
 rtl/spi_triangle_rx.sv | 200 ++++++++++++++++++++
 tb/tb_spi_triangle_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_triangle_rx.sv
// Oversampled SPI mode-0 slave: command byte + WIDTH-bit triangle record -> single-cycle FIFO push.
// Optional CRC-8 trailer byte checked before the push when SPI_TRIANGLE_CRC8_EN is defined.
module spi_triangle_rx #(
  parameter int         WIDTH        = 240,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] CMD_TRIANGLE = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_clk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  input  logic             triangle_full,
  output logic [WIDTH-1:0] triangle_wrdata,
  output logic             triangle_push,
  output logic             overflow,
  output logic             frame_error
);

  localparam int BYTES = WIDTH / 8;
  localparam int BCW   = $clog2(BYTES + 1);

`ifdef SPI_TRIANGLE_CRC8_EN
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_PAYLOAD, S_CHECK, S_PUSH, S_DISCARD} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_PAYLOAD, S_PUSH, S_DISCARD} state_t;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   armed_q, armed_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [WIDTH-1:0]       wrdata_q, wrdata_d;
  logic                   overflow_q, overflow_d;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, bit_en, byte_done, last_payload;
  logic [7:0] rx_byte;

`ifdef SPI_TRIANGLE_CRC8_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s         = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise    = sclk_s & ~sclk_prev_q;
  assign rx_byte      = {shift_q[6:0], mosi_s};
  assign last_payload = (byte_cnt_q == BCW'(BYTES - 1));

  always_comb begin
    bit_en = 1'b0;
    if (sclk_rise && !cs_s) begin
      case (state_q)
        S_CMD, S_PAYLOAD: bit_en = 1'b1;
`ifdef SPI_TRIANGLE_CRC8_EN
        S_CHECK:          bit_en = 1'b1;
`endif
        default:          bit_en = 1'b0;
      endcase
    end
    byte_done = bit_en && (bit_cnt_q == 3'd7);
  end

  // Armed only once cs_n has been genuinely sampled high after reset, so a
  // frame already in progress when reset lifts is ignored.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sclk_prev_d = sclk_s;
    armed_d     = armed_q | (cs_s & fill_q[SYNC_STAGES-1]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (armed_q && !cs_s) state_d = S_CMD;
      S_CMD: begin
        if (cs_s)           state_d = S_IDLE;
        else if (byte_done) state_d = (rx_byte == CMD_TRIANGLE) ? S_PAYLOAD : S_DISCARD;
      end
      S_PAYLOAD: begin
`ifdef SPI_TRIANGLE_CRC8_EN
        if (cs_s)                              state_d = S_IDLE;
        else if (byte_done && last_payload)    state_d = S_CHECK;
`else
        if (cs_s)                              state_d = S_IDLE;
        else if (byte_done && last_payload)    state_d = S_PUSH;
`endif
      end
`ifdef SPI_TRIANGLE_CRC8_EN
      S_CHECK: begin
        if (cs_s)           state_d = S_IDLE;
        else if (byte_done) state_d = (rx_byte == crc_q) ? S_PUSH : S_DISCARD;
      end
`endif
      S_PUSH:    state_d = cs_s ? S_IDLE : S_DISCARD;
      S_DISCARD: if (cs_s) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    wrdata_d   = wrdata_q;
    overflow_d = overflow_q | ((state_q == S_PUSH) & triangle_full);
`ifdef SPI_TRIANGLE_CRC8_EN
    crc_d      = crc_q;
    if (byte_done && (state_q == S_CMD || state_q == S_PAYLOAD)) crc_d = crc8_byte(crc_q, rx_byte);
    if (state_q == S_IDLE) crc_d = 8'h00;
`endif
    if (bit_en) begin
      shift_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (byte_done && state_q == S_PAYLOAD) begin
      byte_cnt_d = byte_cnt_q + BCW'(1);
      for (int k = 0; k < BYTES; k++) begin
        if (byte_cnt_q == BCW'(k)) wrdata_d[WIDTH-1-8*k -: 8] = rx_byte;
      end
    end
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = '0;
      shift_d    = 8'h00;
    end
  end

  always_comb begin
    triangle_push = (state_q == S_PUSH) && !triangle_full;
    frame_error   = 1'b0;
    case (state_q)
      S_CMD:     frame_error = cs_s || (byte_done && rx_byte != CMD_TRIANGLE);
      S_PAYLOAD: frame_error = cs_s;
`ifdef SPI_TRIANGLE_CRC8_EN
      S_CHECK:   frame_error = cs_s || (byte_done && rx_byte != crc_q);
`endif
      default:   frame_error = 1'b0;
    endcase
  end

  assign triangle_wrdata = wrdata_q;
  assign overflow        = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      shift_q     <= 8'h00;
      wrdata_q    <= '0;
      overflow_q  <= 1'b0;
`ifdef SPI_TRIANGLE_CRC8_EN
      crc_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      sclk_prev_q <= sclk_prev_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      wrdata_q    <= wrdata_d;
      overflow_q  <= overflow_d;
`ifdef SPI_TRIANGLE_CRC8_EN
      crc_q       <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_triangle_rx.sv
// Bench for spi_triangle_rx: bit-banged SPI frames at clk/8, scoreboard of expected pushes.
module tb_spi_triangle_rx;

  localparam int WIDTH = 240;
  localparam int BYTES = WIDTH / 8;
  localparam int SYNC  = 2;
`ifdef SPI_TRIANGLE_CRC8_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             spi_clk = 1'b0;
  logic             spi_cs_n = 1'b1;
  logic             spi_mosi = 1'b0;
  logic             triangle_full = 1'b0;
  logic [WIDTH-1:0] triangle_wrdata;
  logic             triangle_push;
  logic             overflow;
  logic             frame_error;

  spi_triangle_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CMD_TRIANGLE(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .triangle_full(triangle_full), .triangle_wrdata(triangle_wrdata),
    .triangle_push(triangle_push), .overflow(overflow), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int push_cyc = -100;
  int push_cnt = 0;
  int ferr_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_w;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst_n && frame_error) ferr_cnt = ferr_cnt + 1;
    if (triangle_push) begin
      push_cnt = push_cnt + 1;
      push_cyc = cyc;
      vectors  = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL unexpected_push data=%h", triangle_wrdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (triangle_wrdata !== exp_w) begin
          miscompares = miscompares + 1;
          $display("FAIL push_data got=%h exp=%h", triangle_wrdata, exp_w);
        end
      end
    end
  end

  // Serial (bit-at-a-time) CRC-8, poly 0x07, init 0, no reflection.
  function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] rec(input logic [7:0] base);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < BYTES; k++) r[WIDTH-1-8*k -: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      last_rise_cyc = cyc;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int nbytes, input logic [7:0] base,
                            input bit add_crc, input bit flip_crc, input int extra);
    logic [7:0] c;
    logic [7:0] d;
    c = crc_ref(8'h00, cmd);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_byte(cmd);
    for (int k = 0; k < nbytes; k++) begin
      d = base + 8'(k);
      spi_byte(d);
      c = crc_ref(c, d);
    end
    if (add_crc) spi_byte(flip_crc ? (c ^ 8'h01) : c);
    for (int k = 0; k < extra; k++) spi_byte(8'hA5);
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    int pc;
    rst_n = 1'b0;
    spi_cs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      spi_clk  = ~spi_clk;
      spi_mosi = ~spi_mosi;
      vectors = vectors + 4;
      if (triangle_push !== 1'b0) begin miscompares++; $display("FAIL reset_push got=%b exp=0", triangle_push); end
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
      if (triangle_wrdata !== '0) begin miscompares++; $display("FAIL reset_wrdata got=%h exp=0", triangle_wrdata); end
    end
    spi_clk = 1'b0;
    pc = push_cnt;
    rst_n = 1'b1;
    // Frame already underway when reset lifts: must be ignored entirely.
    spi_byte(8'h01);
    for (int k = 0; k < BYTES; k++) spi_byte(8'(k + 5));
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    vectors = vectors + 3;
    if (push_cnt !== pc) begin miscompares++; $display("FAIL reset_frame_push got=%0d exp=%0d", push_cnt, pc); end
    if (ferr_cnt !== 0) begin miscompares++; $display("FAIL reset_frame_err got=%0d exp=0", ferr_cnt); end
    if (triangle_wrdata !== '0) begin miscompares++; $display("FAIL reset_frame_wrdata got=%h exp=0", triangle_wrdata); end
  endtask

  task automatic test_basic();
    int pc, fe;
    pc = push_cnt; fe = ferr_cnt;
    exp_q.push_back(rec(8'h00));
    send_frame(8'h01, BYTES, 8'h00, CRC_ON, 1'b0, 0);
    vectors = vectors + 4;
    if (push_cnt !== pc + 1) begin miscompares++; $display("FAIL basic_push_count got=%0d exp=%0d", push_cnt, pc + 1); end
    if (push_cyc - last_rise_cyc !== SYNC + 1) begin
      miscompares++; $display("FAIL basic_latency got=%0d exp=%0d", push_cyc - last_rise_cyc, SYNC + 1);
    end
    if (ferr_cnt !== fe) begin miscompares++; $display("FAIL basic_frame_error got=%0d exp=%0d", ferr_cnt, fe); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_full();
    int pc;
    pc = push_cnt;
    triangle_full = 1'b1;
    send_frame(8'h01, BYTES, 8'h20, CRC_ON, 1'b0, 0);
    triangle_full = 1'b0;
    vectors = vectors + 2;
    if (push_cnt !== pc) begin miscompares++; $display("FAIL full_push got=%0d exp=%0d", push_cnt, pc); end
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL full_overflow got=%b exp=1", overflow); end
    exp_q.push_back(rec(8'h40));
    send_frame(8'h01, BYTES, 8'h40, CRC_ON, 1'b0, 0);
    vectors = vectors + 2;
    if (push_cnt !== pc + 1) begin miscompares++; $display("FAIL full_next_push got=%0d exp=%0d", push_cnt, pc + 1); end
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL full_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_bad_cmd();
    int pc, fe;
    pc = push_cnt; fe = ferr_cnt;
    send_frame(8'h55, BYTES, 8'h10, CRC_ON, 1'b0, 0);
    vectors = vectors + 2;
    if (ferr_cnt !== fe + 1) begin miscompares++; $display("FAIL badcmd_error got=%0d exp=%0d", ferr_cnt, fe + 1); end
    if (push_cnt !== pc) begin miscompares++; $display("FAIL badcmd_push got=%0d exp=%0d", push_cnt, pc); end
  endtask

  task automatic test_abort();
    int pc, fe;
    pc = push_cnt; fe = ferr_cnt;
    send_frame(8'h01, 13, 8'h60, 1'b0, 1'b0, 0);
    vectors = vectors + 2;
    if (ferr_cnt !== fe + 1) begin miscompares++; $display("FAIL abort_error got=%0d exp=%0d", ferr_cnt, fe + 1); end
    if (push_cnt !== pc) begin miscompares++; $display("FAIL abort_push got=%0d exp=%0d", push_cnt, pc); end
    exp_q.push_back(rec(8'h80));
    send_frame(8'h01, BYTES, 8'h80, CRC_ON, 1'b0, 0);
    vectors = vectors + 2;
    if (push_cnt !== pc + 1) begin miscompares++; $display("FAIL abort_next_push got=%0d exp=%0d", push_cnt, pc + 1); end
    if (ferr_cnt !== fe + 1) begin miscompares++; $display("FAIL abort_next_error got=%0d exp=%0d", ferr_cnt, fe + 1); end
  endtask

  task automatic test_back_to_back();
    int pc, fe;
    pc = push_cnt; fe = ferr_cnt;
    exp_q.push_back(rec(8'h90));
    exp_q.push_back(rec(8'hB0));
    send_frame(8'h01, BYTES, 8'h90, CRC_ON, 1'b0, 0);
    send_frame(8'h01, BYTES, 8'hB0, CRC_ON, 1'b0, 2);
    vectors = vectors + 2;
    if (push_cnt !== pc + 2) begin miscompares++; $display("FAIL b2b_push got=%0d exp=%0d", push_cnt, pc + 2); end
    if (ferr_cnt !== fe) begin miscompares++; $display("FAIL b2b_error got=%0d exp=%0d", ferr_cnt, fe); end
  endtask

`ifdef SPI_TRIANGLE_CRC8_EN
  task automatic test_crc();
    int pc, fe;
    pc = push_cnt; fe = ferr_cnt;
    exp_q.push_back(rec(8'h33));
    send_frame(8'h01, BYTES, 8'h33, 1'b1, 1'b0, 0);
    vectors = vectors + 1;
    if (push_cnt !== pc + 1) begin miscompares++; $display("FAIL crc_good_push got=%0d exp=%0d", push_cnt, pc + 1); end
    send_frame(8'h01, BYTES, 8'h33, 1'b1, 1'b1, 0);
    vectors = vectors + 2;
    if (push_cnt !== pc + 1) begin miscompares++; $display("FAIL crc_bad_push got=%0d exp=%0d", push_cnt, pc + 1); end
    if (ferr_cnt !== fe + 1) begin miscompares++; $display("FAIL crc_bad_error got=%0d exp=%0d", ferr_cnt, fe + 1); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_bad_cmd();
    test_abort();
    test_back_to_back();
`ifdef SPI_TRIANGLE_CRC8_EN
    test_crc();
`endif
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
